// File: rtl/fpm_share_ctrl.sv
// rtl/fpm_share_ctrl.sv - round-robin sequencer sharing one combinational FP multiplier
// One operation in flight; zero operands bypass the multiplier entirely.
module fpm_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [WIDTH-1:0]             resp_data,
  output logic [WIDTH-1:0]             mul_a,
  output logic [WIDTH-1:0]             mul_b,
  output logic                         mul_en,
  input  logic [WIDTH-1:0]             mul_c,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               mul_en_q, mul_en_d;

  logic               win_found;
  logic [GW-1:0]      win_idx;
  logic [GW-1:0]      scan_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic [WIDTH-1:0]   win_a, win_b;
  logic               zero_bypass;

  // Search starts one past the last grant and wraps, giving round-robin order.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (scan_idx == GW'(NUM_REQ - 1)) ? '0 : scan_idx + GW'(1);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    if (win_found) win_oh[win_idx] = 1'b1;
    grant_oh = '0;
    grant_oh[grant_q] = 1'b1;
  end

  assign win_a       = req_a[win_idx*WIDTH +: WIDTH];
  assign win_b       = req_b[win_idx*WIDTH +: WIDTH];
  assign zero_bypass = (win_a[WIDTH-2:0] == '0) || (win_b[WIDTH-2:0] == '0);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_en_d     = mul_en_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          mul_a_d      = win_a;
          mul_b_d      = win_b;
          grant_d      = win_idx;
          last_grant_d = win_idx;
          if (zero_bypass) begin
            resp_data_d  = {win_a[WIDTH-1] ^ win_b[WIDTH-1], {(WIDTH-1){1'b0}}};
            resp_valid_d = win_oh;
            state_d      = RESP;
          end else begin
            cnt_d    = CW'(MUL_LAT - 1);
            mul_en_d = 1'b1;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          resp_data_d  = mul_c;
          mul_en_d     = 1'b0;
          resp_valid_d = grant_oh;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready[grant_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = '0;
        mul_en_d     = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_en_q     <= mul_en_d;
    end
  end

  assign req_ready  = (state_q == IDLE) ? win_oh : '0;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_en     = mul_en_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_fpm_share_ctrl.sv
// tb/tb_fpm_share_ctrl.sv - self-checking bench for fpm_share_ctrl
module tb_fpm_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NUM_REQ-1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]         resp_data, mul_a, mul_b, mul_c;
  logic                     mul_en, busy;
  logic [1:0]               grant_id;

  logic [1:0]  r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
  logic [63:0] r1_req_a, r1_req_b;
  logic [31:0] r1_resp_data, r1_mul_a, r1_mul_b, r1_mul_c;
  logic        r1_mul_en, r1_busy;
  logic [0:0]  r1_grant_id;

  logic [31:0] a_arr [NUM_REQ];
  logic [31:0] b_arr [NUM_REQ];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_last = NUM_REQ - 1;
  int last_hs = 0;
  int hs_gap = 0;
  int wait_cycles = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external multiplier: known product for the reference case, a fixed hash otherwise.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h13579BDF;
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    return fmul_model(a, b);
  endfunction

  function automatic int model_winner(input logic [NUM_REQ-1:0] m);
    for (int k = 1; k <= NUM_REQ; k++)
      if (m[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 4) == 0) v[30:0] = 31'd0;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_a[g*WIDTH +: WIDTH] = a_arr[g];
    assign req_b[g*WIDTH +: WIDTH] = b_arr[g];
  end

  assign mul_c    = fmul_model(mul_a, mul_b);
  assign r1_mul_c = fmul_model(r1_mul_a, r1_mul_b);

  fpm_share_ctrl #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_c(mul_c),
    .busy(busy), .grant_id(grant_id)
  );

  fpm_share_ctrl #(.NUM_REQ(2), .WIDTH(32), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_a(r1_req_a), .req_b(r1_req_b),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready), .resp_data(r1_resp_data),
    .mul_a(r1_mul_a), .mul_b(r1_mul_b), .mul_en(r1_mul_en), .mul_c(r1_mul_c),
    .busy(r1_busy), .grant_id(r1_grant_id)
  );

  task automatic refresh_slot(input int i);
    req_valid[i] = ($urandom_range(0, 3) != 0);
    a_arr[i] = rand_op();
    b_arr[i] = rand_op();
  endtask

  // One complete request/response; expectations come from the model, not the DUT.
  task automatic do_txn(input string tag, input int stall, input bit refresh);
    int w, t, lat, en, el;
    logic [NUM_REQ-1:0] oh;
    logic [31:0] ea, eb, er, held;
    bit byp;
    #1;
    w = model_winner(req_valid);
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    t = 0;
    while (req_ready == '0 && t < 20) begin
      @(posedge clk); #2; t++;
    end
    wait_cycles = t;
    checks++;
    if (w < 0 || req_ready !== oh) begin
      errors++;
      $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, oh);
      return;
    end
    hs_gap = cyc - last_hs;
    last_hs = cyc;
    ea = a_arr[w];
    eb = b_arr[w];
    byp = (ea[30:0] == 31'd0) || (eb[30:0] == 31'd0);
    er = exp_result(ea, eb);
    el = byp ? 1 : MUL_LAT + 1;
    m_last = w;
    if (stall > 0) resp_ready[w] = 1'b0;
    lat = 0;
    en = 0;
    do begin
      @(posedge clk); #2; lat++;
      if (lat == 1 && refresh) refresh_slot(w);
      if (mul_en) en++;
      checks++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s in_flight: req_ready=%b busy=%b expected 0 and 1", tag, req_ready, busy);
      end
    end while (resp_valid === '0 && lat < 20);
    checks++;
    if (lat !== el) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, el);
    end
    checks++;
    if (en !== (byp ? 0 : MUL_LAT)) begin
      errors++;
      $display("FAIL %s mul_en_cycles: got %0d expected %0d", tag, en, byp ? 0 : MUL_LAT);
    end
    checks++;
    if (resp_valid !== oh) begin
      errors++;
      $display("FAIL %s resp_valid: got %b expected %b", tag, resp_valid, oh);
    end
    checks++;
    if (resp_data !== er) begin
      errors++;
      $display("FAIL %s resp_data: got %h expected %h", tag, resp_data, er);
    end
    checks++;
    if (int'(grant_id) !== w) begin
      errors++;
      $display("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, w);
    end
    held = er;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #2;
      checks++;
      if (resp_valid !== oh || resp_data !== held || req_ready !== '0) begin
        errors++;
        $display("FAIL %s stall: resp_valid=%b data=%h req_ready=%b expected %b %h 0",
                 tag, resp_valid, resp_data, req_ready, oh, held);
      end
    end
    if (stall > 0) resp_ready[w] = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (resp_valid !== '0) begin
      errors++;
      $display("FAIL %s release: resp_valid=%b expected 0", tag, resp_valid);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (busy !== 1'b0 || mul_en !== 1'b0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b mul_en=%b resp_valid=%b expected 0", busy, mul_en, resp_valid);
    end
    checks++;
    if (resp_data !== '0 || mul_a !== '0 || mul_b !== '0) begin
      errors++;
      $display("FAIL reset_data: resp_data=%h mul_a=%h mul_b=%h expected 0", resp_data, mul_a, mul_b);
    end
    checks++;
    if (grant_id !== 2'd0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_grant: grant_id=%0d req_ready=%b expected 0", grant_id, req_ready);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    m_last = NUM_REQ - 1;
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = 32'h40000000 + 32'(i) * 32'h00100000;
      b_arr[i] = 32'h3F800000 + 32'(i);
    end
    req_valid = '1;
    for (int k = 0; k < NUM_REQ + 1; k++) begin
      do_txn("round_robin", 0, 1'b0);
      if (k > 0) begin
        checks++;
        if (hs_gap !== MUL_LAT + 2) begin
          errors++;
          $display("FAIL rr_spacing: got %0d expected %0d", hs_gap, MUL_LAT + 2);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single_op;
    a_arr[0] = 32'h3FC00000;
    b_arr[0] = 32'h40000000;
    req_valid = 4'b0001;
    do_txn("single_op", 0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    a_arr[1] = 32'h40490FDB;
    b_arr[1] = 32'hC0000000;
    a_arr[3] = 32'h3E800000;
    b_arr[3] = 32'h42C80000;
    req_valid = 4'b1010;
    do_txn("backpressure", 5, 1'b0);
    req_valid[1] = 1'b0;
    do_txn("after_bp", 0, 1'b0);
    checks++;
    if (wait_cycles !== 0) begin
      errors++;
      $display("FAIL bp_next_grant_delay: got %0d expected 0", wait_cycles);
    end
    req_valid = '0;
  endtask

  task automatic test_zero_bypass;
    a_arr[2] = 32'h80000000;
    b_arr[2] = 32'h3F800000;
    req_valid = 4'b0100;
    do_txn("zero_bypass", 0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i]) refresh_slot(i);
      if (req_valid == '0) req_valid[n % NUM_REQ] = 1'b1;
      do_txn("random", int'($urandom_range(0, 3)), 1'b1);
    end
    req_valid = '0;
    @(posedge clk); #2;
    if (resp_valid !== '0 || busy !== 1'b0) @(posedge clk);
  endtask

  task automatic test_reset_mid_op;
    int t;
    a_arr[0] = 32'h40A00000;
    b_arr[0] = 32'h40400000;
    req_valid = 4'b0001;
    #1;
    t = 0;
    while (req_ready == '0 && t < 20) begin
      @(posedge clk); #2; t++;
    end
    @(posedge clk); #2;
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || mul_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: busy=%b mul_en=%b expected 1", busy, mul_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mul_en !== 1'b0 || resp_valid !== '0 || grant_id !== 2'd0 ||
        mul_a !== '0 || mul_b !== '0 || resp_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: busy=%b mul_en=%b resp_valid=%b grant_id=%0d mul_a=%h expected all 0",
               busy, mul_en, resp_valid, grant_id, mul_a);
    end
    a_arr[1] = 32'h3F000000;
    b_arr[1] = 32'h41200000;
    a_arr[2] = 32'h40800000;
    b_arr[2] = 32'h40800000;
    req_valid = 4'b0110;
    @(posedge clk); #2;
    rst_n = 1'b1;
    m_last = NUM_REQ - 1;
    do_txn("rst_mid_first", 0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_lat1;
    int lat, en;
    r1_req_a[31:0] = 32'h3FC00000;
    r1_req_b[31:0] = 32'h40000000;
    r1_req_valid = 2'b01;
    #1;
    checks++;
    if (r1_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL lat1_grant: req_ready=%b expected 01", r1_req_ready);
    end
    lat = 0;
    en = 0;
    do begin
      @(posedge clk); #2; lat++;
      r1_req_valid = 2'b00;
      if (r1_mul_en) en++;
    end while (r1_resp_valid === 2'b00 && lat < 20);
    checks++;
    if (lat !== 2 || en !== 1) begin
      errors++;
      $display("FAIL lat1_timing: latency=%0d mul_en_cycles=%0d expected 2 and 1", lat, en);
    end
    checks++;
    if (r1_resp_valid !== 2'b01 || r1_resp_data !== 32'h40400000) begin
      errors++;
      $display("FAIL lat1_resp: resp_valid=%b data=%h expected 01 40400000", r1_resp_valid, r1_resp_data);
    end
    @(posedge clk); #2;
    checks++;
    if (r1_resp_valid !== 2'b00 || r1_busy !== 1'b0) begin
      errors++;
      $display("FAIL lat1_release: resp_valid=%b busy=%b expected 00 0", r1_resp_valid, r1_busy);
    end
  endtask

  initial begin
    req_valid = '0;
    resp_ready = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    r1_req_valid = '0;
    r1_resp_ready = 2'b11;
    r1_req_a = '0;
    r1_req_b = '0;
    test_reset;
    test_round_robin;
    test_single_op;
    test_backpressure;
    test_zero_bypass;
    test_random;
    test_reset_mid_op;
    test_lat1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
